// File: rtl/spi_slave_sync_if.sv
// SPI slave bundle: serial pins, TX/RX word handshakes and status flags.
// slave modport is used by spi_slave_sync; master modport by whoever drives it.
interface spi_slave_sync_if #(
  parameter int WIDTH = 8
);
  logic             slave_enable_i;
  logic             slave_sel_i;
  logic             slave_clk_i;
  logic             mosi_i;
  logic             miso_o;
  logic             miso_oe_o;
  logic [WIDTH-1:0] data_tx_i;
  logic             tx_valid_i;
  logic             tx_ready_o;
  logic [WIDTH-1:0] data_rx_o;
  logic             rx_valid_o;
  logic             rx_ready_i;
  logic             busy_o;
  logic             overrun_o;
  logic             underrun_o;

  modport slave (
    input  slave_enable_i, slave_sel_i, slave_clk_i, mosi_i,
    input  data_tx_i, tx_valid_i, rx_ready_i,
    output miso_o, miso_oe_o, tx_ready_o, data_rx_o, rx_valid_o,
    output busy_o, overrun_o, underrun_o
  );

  modport master (
    output slave_enable_i, slave_sel_i, slave_clk_i, mosi_i,
    output data_tx_i, tx_valid_i, rx_ready_i,
    input  miso_o, miso_oe_o, tx_ready_o, data_rx_o, rx_valid_o,
    input  busy_o, overrun_o, underrun_o
  );
endinterface

// File: rtl/spi_slave_sync.sv
// System-clock SPI slave. SCLK, CS_n and MOSI are oversampled into clk_i; all
// state lives in that one domain. Mode, word width and bit order are parameters.
// Optional macro SPI_SLAVE_RX_FIFO_EN: RX storage becomes a RX_DEPTH-entry FIFO
// instead of a single holding register.
module spi_slave_sync #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int RX_DEPTH    = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  spi_slave_sync_if.slave sif
);
  localparam int   CW          = $clog2(WIDTH);
  localparam logic SCLK_IDLE   = (CPOL != 0);
  localparam bit   SAMPLE_RISE = (CPOL == CPHA);

  if (WIDTH < 4 || SYNC_STAGES < 2 || RX_DEPTH < 1 || (RX_DEPTH & (RX_DEPTH - 1)) != 0)
  begin : g_bad_param
    $error("spi_slave_sync: illegal parameter set");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
  logic [SYNC_STAGES:0]   flush_q;
  logic cs_s, sck_s, mosi_s;
  logic cs_prev_q, sck_prev_q, mosi_q;
  logic cs_fall_q, cs_rise_q, sample_q, shift_q;

  state_t state_q, state_d;
  logic   busy, oe;
  logic   shifting, start, abort, word_end, load, und_fire;

  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] rx_sr_q, rx_next;
  logic [WIDTH-1:0] tx_sr_q, tx_shifted;
  logic             tx_head, miso_q, skip_q, und_pend_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q, tx_accept;
  logic             underrun_q, overrun_q;
  logic             push, pop;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Synchroniser chains, preset to the idle bus state
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= {SYNC_STAGES{SCLK_IDLE}};
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], sif.slave_sel_i};
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sif.slave_clk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], sif.mosi_i};
    end
  end

  // Registered edge detect; CS fall is ignored until the preset chain has been
  // flushed, so a CS_n held low through reset does not start a frame
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      flush_q    <= '0;
      cs_prev_q  <= 1'b1;
      sck_prev_q <= SCLK_IDLE;
      mosi_q     <= 1'b0;
      cs_fall_q  <= 1'b0;
      cs_rise_q  <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      flush_q    <= {flush_q[SYNC_STAGES-1:0], 1'b1};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
      mosi_q     <= mosi_s;
      cs_fall_q  <= flush_q[SYNC_STAGES] & cs_prev_q & ~cs_s;
      cs_rise_q  <= ~cs_prev_q & cs_s;
      sample_q   <= SAMPLE_RISE ? (~sck_prev_q & sck_s) : (sck_prev_q & ~sck_s);
      shift_q    <= SAMPLE_RISE ? (sck_prev_q & ~sck_s) : (~sck_prev_q & sck_s);
    end
  end

  assign shifting  = (state_q == SHIFT);
  assign start     = (state_q == IDLE) & cs_fall_q & sif.slave_enable_i;
  assign abort     = shifting & (cs_rise_q | ~sif.slave_enable_i);
  assign word_end  = shifting & sample_q & (bit_cnt_q == CW'(WIDTH - 1));
  assign load      = start | (word_end & ~abort);
  assign und_fire  = shifting & sample_q & und_pend_q & ~abort;
  assign tx_accept = sif.tx_valid_i & ~hold_full_q;

  assign rx_next    = (MSB_FIRST != 0) ? {rx_sr_q[WIDTH-2:0], mosi_q} : {mosi_q, rx_sr_q[WIDTH-1:1]};
  assign tx_head    = (MSB_FIRST != 0) ? tx_sr_q[WIDTH-1] : tx_sr_q[0];
  assign tx_shifted = (MSB_FIRST != 0) ? {tx_sr_q[WIDTH-2:0], 1'b0} : {1'b0, tx_sr_q[WIDTH-1:1]};

  // FSM state register
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (abort) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = 1'b0;
    oe   = 1'b0;
    if (state_q == SHIFT) begin
      busy = 1'b1;
      oe   = 1'b1;
    end
  end

  // Shift registers, bit counter and TX holding register. A word-end reload
  // that finds the holding reg empty only flags underrun once the next word
  // actually starts clocking, so the final word of a frame does not pulse it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      miso_q      <= 1'b0;
      skip_q      <= 1'b0;
      und_pend_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_full_q <= (hold_full_q & ~load) | tx_accept;
      if (tx_accept) hold_q <= sif.data_tx_i;
      underrun_q <= (start & ~hold_full_q) | und_fire;
      if (abort) begin
        bit_cnt_q  <= '0;
        skip_q     <= 1'b0;
        und_pend_q <= 1'b0;
      end else begin
        if (shifting & sample_q) begin
          rx_sr_q   <= rx_next;
          bit_cnt_q <= word_end ? '0 : bit_cnt_q + CW'(1);
        end
        if (load) begin
          tx_sr_q    <= hold_full_q ? hold_q : '0;
          skip_q     <= (CPHA == 0) && word_end;
          und_pend_q <= word_end & ~hold_full_q;
          if (start) miso_q <= 1'b0;
        end else begin
          if (und_fire) und_pend_q <= 1'b0;
          if (shifting & shift_q) begin
            if (skip_q) skip_q <= 1'b0;
            else begin
              miso_q  <= tx_head;
              tx_sr_q <= tx_shifted;
            end
          end
        end
      end
    end
  end

  assign push = word_end;
  assign pop  = sif.rx_valid_o & sif.rx_ready_i;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
  logic [WIDTH-1:0] mem_q [RX_DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             empty, full;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // RX FIFO; a pop frees a slot for a same-cycle push
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < RX_DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push & full & ~pop;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && (!full || pop)) begin
        mem_q[wptr_q[AW-1:0]] <= rx_next;
        wptr_q                <= wptr_q + 1'b1;
      end
    end
  end

  assign sif.data_rx_o  = mem_q[rptr_q[AW-1:0]];
  assign sif.rx_valid_o = ~empty;
`else
  logic [WIDTH-1:0] rx_q;
  logic             rx_valid_q;

  // Single-entry RX register; a pop frees it for a same-cycle push
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (push && (!rx_valid_q || pop)) begin
        rx_q       <= rx_next;
        rx_valid_q <= 1'b1;
      end else begin
        if (pop)  rx_valid_q <= 1'b0;
        if (push) overrun_q  <= 1'b1;
      end
    end
  end

  assign sif.data_rx_o  = rx_q;
  assign sif.rx_valid_o = rx_valid_q;
`endif

  assign sif.miso_oe_o  = oe;
  assign sif.miso_o     = oe ? ((CPHA == 0) ? tx_head : miso_q) : 1'bz;
  assign sif.busy_o     = busy;
  assign sif.tx_ready_o = ~hold_full_q;
  assign sif.overrun_o  = overrun_q;
  assign sif.underrun_o = underrun_q;
endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a mode-0 MSB-first instance and a mode-3 LSB-first
// instance. Stimulus pushes expected RX words; monitors pop and compare on each
// RX handshake and count overrun/underrun pulses.
module tb_spi_slave_sync;
  localparam int W  = 8;
  localparam int H  = 8;   // clk cycles per SCLK half period
  localparam int SS = 2;
`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int NOVR = 5;
`else
  localparam int NOVR = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  spi_slave_sync_if #(.WIDTH(W)) s0 ();
  spi_slave_sync_if #(.WIDTH(W)) s3 ();

  logic [1:0]        cs_r = 2'b11, sclk_r = 2'b10, mosi_r = 2'b00;
  logic [1:0]        txv_r = 2'b00, rxr_r = 2'b11, en_r = 2'b11;
  logic [1:0][W-1:0] txd_r = '0;
  wire  [1:0]        miso_w  = {s3.miso_o, s0.miso_o};
  wire  [1:0]        txrdy_w = {s3.tx_ready_o, s0.tx_ready_o};

  assign s0.slave_enable_i = en_r[0];   assign s3.slave_enable_i = en_r[1];
  assign s0.slave_sel_i    = cs_r[0];   assign s3.slave_sel_i    = cs_r[1];
  assign s0.slave_clk_i    = sclk_r[0]; assign s3.slave_clk_i    = sclk_r[1];
  assign s0.mosi_i         = mosi_r[0]; assign s3.mosi_i         = mosi_r[1];
  assign s0.data_tx_i      = txd_r[0];  assign s3.data_tx_i      = txd_r[1];
  assign s0.tx_valid_i     = txv_r[0];  assign s3.tx_valid_i     = txv_r[1];
  assign s0.rx_ready_i     = rxr_r[0];  assign s3.rx_ready_i     = rxr_r[1];

  spi_slave_sync #(.WIDTH(W), .CPOL(0), .CPHA(0), .MSB_FIRST(1), .SYNC_STAGES(SS))
    u0 (.clk_i(clk), .reset_i(rst), .sif(s0));
  spi_slave_sync #(.WIDTH(W), .CPOL(1), .CPHA(1), .MSB_FIRST(0), .SYNC_STAGES(SS))
    u3 (.clk_i(clk), .reset_i(rst), .sif(s3));

  int checks = 0, errors = 0;
  logic [W-1:0] exp_q0[$], exp_q1[$];
  int n_ovr0 = 0, n_und0 = 0;
  bit lat_chk = 0;
  int t_last = 0;
  logic rxv_prev0 = 1'b0;
  logic [W-1:0] mi;
  int u_base, o_base;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Monitor: RX scoreboard, latency, pulse counters
  always @(negedge clk) begin
    if (s0.overrun_o)  n_ovr0++;
    if (s0.underrun_o) n_und0++;
    if (lat_chk && s0.rx_valid_o && !rxv_prev0) begin
      chk("rx_latency", cyc - t_last, SS + 2);
      lat_chk = 0;
    end
    rxv_prev0 = s0.rx_valid_o;
    if (s0.rx_valid_o && rxr_r[0]) begin
      if (exp_q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx0_unexpected act=%0h", s0.data_rx_o);
      end else chk("rx0_data", s0.data_rx_o, exp_q0.pop_front());
    end
    if (s3.rx_valid_o && rxr_r[1]) begin
      if (exp_q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx3_unexpected act=%0h", s3.data_rx_o);
      end else chk("rx3_data", s3.data_rx_o, exp_q1.pop_front());
    end
  end

  task automatic wn(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_offer(int d, logic [W-1:0] v);
    int k = 0;
    @(negedge clk);
    while (!txrdy_w[d] && k < 200) begin @(negedge clk); k++; end
    if (!txrdy_w[d]) begin
      checks++; errors++;
      $display("FAIL tx_offer_timeout act=0 exp=1");
    end else begin
      txd_r[d] = v; txv_r[d] = 1'b1;
      @(negedge clk);
      txv_r[d] = 1'b0;
    end
  endtask

  task automatic cs_low(int d);
    wn(1); cs_r[d] = 1'b0; wn(H);
  endtask

  task automatic cs_high(int d);
    wn(H); cs_r[d] = 1'b1; wn(H);
  endtask

  // One SPI word from the master's side; captures MISO at each sample point
  task automatic word(int d, logic [W-1:0] mo, int nb, output logic [W-1:0] got);
    logic cp;
    int   idx;
    cp  = (d == 1);
    got = '0;
    for (int i = 0; i < nb; i++) begin
      idx = (d == 0) ? W - 1 - i : i;
      if (!cp) begin
        mosi_r[d] = mo[idx]; wn(H);
        got[idx] = miso_w[d];
        sclk_r[d] = 1'b1;
        if (i == W - 1) t_last = cyc;
        wn(H); sclk_r[d] = 1'b0;
      end else begin
        sclk_r[d] = 1'b0; mosi_r[d] = mo[idx]; wn(H);
        got[idx] = miso_w[d];
        sclk_r[d] = 1'b1;
        if (i == W - 1) t_last = cyc;
        wn(H);
      end
    end
  endtask

  task automatic reset_checks(string tag);
    chk({tag, "_oe"},       s0.miso_oe_o,  0);
    chk({tag, "_tx_ready"}, s0.tx_ready_o, 1);
    chk({tag, "_rx_valid"}, s0.rx_valid_o, 0);
    chk({tag, "_data_rx"},  s0.data_rx_o,  0);
    chk({tag, "_busy"},     s0.busy_o,     0);
    chk({tag, "_overrun"},  s0.overrun_o,  0);
    chk({tag, "_underrun"}, s0.underrun_o, 0);
  endtask

  initial begin
    wn(3);
    reset_checks("rst");
    rst = 1'b0;
    wn(10);

    // Mode 0: TX 0x3C, master sends 0xA5
    tx_offer(0, 8'h3C);
    exp_q0.push_back(8'hA5);
    lat_chk = 1;
    cs_low(0);
    chk("m0_busy", s0.busy_o, 1);
    chk("m0_oe", s0.miso_oe_o, 1);
    word(0, 8'hA5, 8, mi);
    chk("m0_miso", mi, 8'h3C);
    cs_high(0);
    chk("m0_latency_seen", lat_chk, 0);

    // Mode 3 LSB first: TX 0x0F, master sends 0x81
    tx_offer(1, 8'h0F);
    exp_q1.push_back(8'h81);
    cs_low(1);
    word(1, 8'h81, 8, mi);
    chk("m3_miso", mi, 8'h0F);
    cs_high(1);

    // Three back-to-back words, TX loaded twice
    u_base = n_und0;
    tx_offer(0, 8'h11);
    exp_q0.push_back(8'h01); exp_q0.push_back(8'h02); exp_q0.push_back(8'h03);
    cs_low(0);
    fork
      word(0, 8'h01, 8, mi);
      tx_offer(0, 8'h22);
    join
    chk("b2b_miso1", mi, 8'h11);
    word(0, 8'h02, 8, mi);
    chk("b2b_miso2", mi, 8'h22);
    word(0, 8'h03, 8, mi);
    chk("b2b_miso3", mi, 8'h00);
    chk("b2b_busy", s0.busy_o, 1);
    cs_high(0);
    chk("b2b_underrun", n_und0 - u_base, 1);

    // Overrun: consumer stalled
    rxr_r[0] = 1'b0;
    o_base = n_ovr0;
    for (int k = 0; k < NOVR - 1; k++) exp_q0.push_back(8'h40 + 8'(k));
    cs_low(0);
    for (int k = 0; k < NOVR; k++) word(0, 8'h40 + 8'(k), 8, mi);
    cs_high(0);
    chk("ovr_pulses", n_ovr0 - o_base, 1);
    chk("ovr_valid", s0.rx_valid_o, 1);
    chk("ovr_kept", s0.data_rx_o, 8'h40);
    rxr_r[0] = 1'b1;
    wn(4 + NOVR);
    chk("ovr_drained", s0.rx_valid_o, 0);

    // Abort after 5 bits, then a clean word
    cs_low(0);
    word(0, 8'hFF, 5, mi);
    cs_high(0);
    wn(8);
    chk("abort_oe", s0.miso_oe_o, 0);
    chk("abort_busy", s0.busy_o, 0);
    chk("abort_rx_valid", s0.rx_valid_o, 0);
    tx_offer(0, 8'hC3);
    exp_q0.push_back(8'h5A);
    cs_low(0);
    word(0, 8'h5A, 8, mi);
    chk("abort_next_miso", mi, 8'hC3);
    cs_high(0);

    // Reset mid-word with CS_n held low
    tx_offer(0, 8'h99);
    cs_low(0);
    word(0, 8'hF0, 3, mi);
    rst = 1'b1;
    wn(2);
    reset_checks("midrst");
    wn(2);
    rst = 1'b0;
    wn(20);
    chk("midrst_no_restart", s0.busy_o, 0);
    chk("midrst_oe_off", s0.miso_oe_o, 0);
    cs_r[0] = 1'b1; sclk_r[0] = 1'b0; mosi_r[0] = 1'b0;
    wn(H);
    tx_offer(0, 8'h7E);
    exp_q0.push_back(8'hE7);
    cs_low(0);
    word(0, 8'hE7, 8, mi);
    chk("post_rst_miso", mi, 8'h7E);
    cs_high(0);

    for (int k = 0; k < 100; k++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      wn(1);
    end
    chk("sb0_empty", exp_q0.size(), 0);
    chk("sb3_empty", exp_q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
